gray_counter: RTL and testbench
===============================

# gray_counter

Enable-gated Gray-code counter with a sticky overflow flag. It advances one Gray code per enabled clock, wraps to zero after the last code, and latches an overflow indication on the first wrap until reset. It is intended as a small sequencing/state primitive. Its output changes exactly one bit per step, so it is safe to sample across clock domains.

## Interface
- `WIDTH`, default 3: counter width in bits; legal range 2..16.
- `Clk` input, 1 bit: single clock; all state updates on the rising edge.
- `Reset` input, 1 bit: asynchronous, active-low reset; 0 clears all state immediately.
- `En` input, 1 bit: count enable, sampled on the rising edge of `Clk`.
- `Output` output, `WIDTH` bits: current Gray code, registered.
- `Overflow` output, 1 bit: sticky wrap flag, registered.

## Operation
- Internal state:
  - a `WIDTH`-bit binary count `bin`;
  - a 1-bit overflow register `ovf`.
- `Output` = `bin ^ (bin >> 1)`.
  - Computed from registered `bin`, so it is glitch-free per edge.
  - May alternatively be held in its own register, provided it is cycle-identical.
- `Overflow` = `ovf`.
- On a rising edge with `Reset`=1:
  - `En`=0: hold `bin` and `ovf`.
  - `En`=1: `bin` <= `bin` + 1, modulo 2^WIDTH.
  - `En`=1 and `bin` = 2^WIDTH−1: `bin` wraps to 0 and `ovf` <= 1.
- `ovf` is sticky.
  - Once set, only reset clears it.
  - Further wraps leave it at 1.
  - Counting continues normally after overflow.
- Sequence for WIDTH=3: 000, 001, 011, 010, 110, 111, 101, 100, then back to 000.
- Consecutive `Output` values differ in exactly one bit, including across the wrap (100 to 000).

## Timing
- Reset values: `Output`=0 and `Overflow`=0. Both take effect asynchronously when `Reset` falls, with no clock required.
- Reset release is synchronized by design intent only. The first count occurs on the first rising edge with `Reset`=1 and `En`=1.
- Latency: `Output` reflects a count one cycle after the edge that samples `En`=1. There is no combinational path from `En` to the outputs.
- Overflow timing: `Overflow` rises on the same edge that `Output` returns to 0.
  - For WIDTH=3 this is the 8th enabled edge after reset.
- Reset asserted mid-count or after overflow: both outputs go to 0 immediately. Counting restarts from 0.
- `En` toggling between edges has no effect. Only the value at the rising edge matters.

## Structure
- Shared package `gray_pkg`:
  - default width constant `GRAY_W_DEFAULT` = 3;
  - function `bin2gray(bin)` returning `bin ^ (bin >> 1)`.
- Natural sub-module `bin2gray_conv`: purely combinational, parameterized by `WIDTH`, maps binary to Gray.
- Top `gray_counter` holds the binary register and overflow register and instantiates `bin2gray_conv`.
- Optional companion `gray2bin_conv` (prefix-XOR) for verification use only; it is not instantiated in the datapath.

## Test plan
- Reset check: drive `Reset`=0 with no clock edges. Require `Output`=000 and `Overflow`=0 immediately. Release `Reset` with `En`=0 for 5 cycles and require `Output` to stay 000.
- Full sequence: `En`=1 for 8 edges.
  - Require `Output` = 001, 011, 010, 110, 111, 101, 100, 000.
  - Require `Overflow`=0 through the 7th edge and 1 after the 8th.
- Sticky flag: continue `En`=1 for 10 more edges. Require `Output` to wrap normally and `Overflow` to stay 1 throughout.
- Enable gating: count to 011, drop `En` for 4 cycles, then raise it. Require `Output` to hold 011, then advance to 010.
- Asynchronous reset mid-operation: at `Output`=110 with `Overflow`=1, pulse `Reset` low between clock edges. Require both outputs to clear before the next edge and counting to resume from 001.
- Property: for a random `En` pattern over 1000 cycles, every change of `Output` flips exactly one bit. Also require that `gray2bin(Output)` equals the number of enabled edges since reset, modulo 8.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and the binary-to-Gray mapping used by the Gray counter.
package gray_pkg;

  localparam int unsigned GRAY_W_DEFAULT = 3;
  localparam int unsigned GRAY_W_MAX     = 16;

  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_conv.sv
// Combinational binary-to-Gray converter for any width up to GRAY_W_MAX.
module bin2gray_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_c
);

  // Zero-extension keeps the shifted-in MSB at 0, so truncation is exact.
  assign gray_c = WIDTH'(bin2gray(GRAY_W_MAX'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Enable-gated Gray-code counter with a sticky wrap (overflow) flag.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] BIN_LAST = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;

  // Next binary count and sticky flag; the flag sets on the wrap edge.
  always_comb begin
    bin_d = bin_q;
    ovf_d = ovf_q;
    if (En) begin
      bin_d = bin_q + WIDTH'(1);
      if (bin_q == BIN_LAST) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Gray code of the next count, registered so Output comes straight off a flop.
  bin2gray_conv #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin_i  (bin_d),
    .gray_c (gray_d)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Output   = gray_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed testbench for gray_counter at the default 3-bit width.
module tb_gray_counter;

  localparam int unsigned W = 3;

  logic         Clk;
  logic         Reset;
  logic         En;
  logic [W-1:0] Output;
  logic         Overflow;

  int vecs;
  int errs;

  // Gray code for binary counts 0..7
  logic [W-1:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

  gray_counter #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Output   (Output),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] g_exp, input logic o_exp);
    vecs++;
    if (Output !== g_exp || Overflow !== o_exp) begin
      errs++;
      $display("FAIL %s: Output=%b Overflow=%b, expected Output=%b Overflow=%b",
               name, Output, Overflow, g_exp, o_exp);
    end
  endtask

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Async pulse of Reset away from any clock edge (called at posedge+1).
  task automatic pulse_reset();
    #1 Reset = 1'b0;
    #1 Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    En    = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("reset_no_clock", 3'b000, 1'b0);
    step();
    step();
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_release_hold", 3'b000, 1'b0);
    end
  endtask

  task automatic test_full_sequence();
    En = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("full_sequence", gseq[i % 8], (i == 8));
    end
  endtask

  task automatic test_sticky();
    En = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("sticky_overflow", gseq[i % 8], 1'b1);
    end
  endtask

  task automatic test_enable_gating();
    pulse_reset();
    chk("gating_reset", 3'b000, 1'b0);
    En = 1'b1;
    step();
    step();
    chk("gating_reach_011", 3'b011, 1'b0);
    En = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gating_hold", 3'b011, 1'b0);
    end
    En = 1'b1;
    step();
    chk("gating_resume", 3'b010, 1'b0);
  endtask

  task automatic test_async_reset();
    // From count 3: 5 edges reach the wrap, 4 more reach count 4 (110).
    En = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("pre_reset_state", 3'b110, 1'b1);
    pulse_reset();
    chk("async_reset_clear", 3'b000, 1'b0);
    step();
    chk("post_reset_first", 3'b001, 1'b0);
  endtask

  task automatic test_property();
    logic [W-1:0] prev;
    logic         v;
    int           n_en;
    pulse_reset();
    chk("prop_reset", 3'b000, 1'b0);
    n_en = 0;
    for (int i = 0; i < 1000; i++) begin
      prev = Output;
      v    = 1'($urandom_range(0, 1));
      // A glitch on En between edges must not matter.
      En = ~v;
      #2 En = v;
      step();
      if (v) n_en++;
      vecs++;
      if ($countones(Output ^ prev) !== (v ? 1 : 0)) begin
        errs++;
        $display("FAIL prop_one_bit: cycle %0d prev=%b now=%b en=%b", i, prev, Output, v);
      end
      vecs++;
      if (gray2bin(Output) !== W'(n_en % 8)) begin
        errs++;
        $display("FAIL prop_count: cycle %0d gray2bin=%0d expected %0d",
                 i, gray2bin(Output), n_en % 8);
      end
    end
    vecs++;
    if (Overflow !== (n_en >= 8)) begin
      errs++;
      $display("FAIL prop_overflow: Overflow=%b expected %b", Overflow, (n_en >= 8));
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_full_sequence();
    test_sticky();
    test_enable_gating();
    test_async_reset();
    test_property();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
